// File: rtl/des_round_engine.sv
// Iterative DES block core: IP, 16 Feistel rounds (UNROLL per clock), FP, with an on-chip key schedule.
// Encrypts or decrypts one 64-bit block per transaction over a valid/ready handshake.
module des_round_engine #(
  parameter int unsigned UNROLL = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_key,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned ROUNDS = 16;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16)) begin : g_bad_unroll
    $error("des_round_engine: UNROLL must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_e;

  // Permutation tables use DES numbering: entry = 1-based source bit, bit 1 is the MSB.
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // S1..S8, each 4 rows of 16, indexed {box, row(b1,b6), col(b2..b5)}.
  localparam int unsigned SBOX [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[6'(j)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[6'(j)])];
    return y;
  endfunction

  // f-function: E-expansion, subkey XOR, S-boxes, P-permutation.
  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] ex;
    logic [31:0] sb;
    logic [31:0] y;
    logic [5:0]  six;
    for (int j = 0; j < 48; j++) ex[6'(47 - j)] = r[5'(32 - E_T[6'(j)])];
    ex = ex ^ k;
    for (int b = 0; b < 8; b++) begin
      six = ex[6'(47 - 6 * b) -: 6];
      sb[5'(31 - 4 * b) -: 4] = 4'(SBOX[{3'(b), six[5], six[0], six[4:1]}]);
    end
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = sb[5'(32 - P_T[5'(j)])];
    return y;
  endfunction

  // Rotation before round rnd: left by SH[rnd] to encrypt; none then right by SH[18-rnd] to decrypt.
  function automatic logic [1:0] shift_amt(input logic dec, input logic [4:0] rnd);
    logic [4:0] j;
    j = dec ? 5'(5'd18 - rnd) : rnd;
    if (dec && rnd == 5'd1) return 2'd0;
    return (j == 5'd1 || j == 5'd2 || j == 5'd9 || j == 5'd16) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic dec, input logic [1:0] n);
    case (n)
      2'd0:    return x;
      2'd1:    return dec ? {x[0], x[27:1]} : {x[26:0], x[27]};
      default: return dec ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        l_q, l_d, r_q, r_d;
  logic [27:0]        c_q, c_d, d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [63:0]        out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [31:0]        l_nx, r_nx, l_tmp;
  logic [27:0]        c_nx, d_nx;
  logic [1:0]         rnd_sh;

  // UNROLL chained rounds from the registered L/R/C/D.
  always_comb begin : round_cascade
    l_nx   = l_q;
    r_nx   = r_q;
    c_nx   = c_q;
    d_nx   = d_q;
    l_tmp  = '0;
    rnd_sh = '0;
    for (int u = 0; u < UNROLL; u++) begin
      rnd_sh = shift_amt(mode_q, 5'(cnt_q + 5'(u + 1)));
      c_nx   = rot28(c_nx, mode_q, rnd_sh);
      d_nx   = rot28(d_nx, mode_q, rnd_sh);
      l_tmp  = r_nx;
      r_nx   = l_nx ^ f_func(r_nx, perm_pc2({c_nx, d_nx}));
      l_nx   = l_tmp;
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    l_d        = l_q;
    r_d        = r_q;
    c_d        = c_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = perm_ip(in_data);
          {c_d, d_d} = perm_pc1(in_key);
          mode_d     = in_decrypt;
          cnt_d      = '0;
          state_d    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        l_d   = l_nx;
        r_d   = r_nx;
        c_d   = c_nx;
        d_d   = d_nx;
        cnt_d = cnt_q + CNT_W'(UNROLL);
        if (cnt_d == CNT_W'(ROUNDS)) begin
          out_data_d = perm_fp({r_nx, l_nx});
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they register alongside it.
  always_comb begin : output_decode
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin : state_reg
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine: five instances (UNROLL 1,2,4,8,16) sharing clock, reset and block inputs.
module tb_des_round_engine;

  localparam int unsigned NINST = 5;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K3 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P3 = 64'h8787878787878787;
  localparam logic [63:0] C3 = 64'h0000000000000000;
  // K1 with the low (parity) bit of every byte inverted.
  localparam logic [63:0] K6 = 64'h123556789ABDDEF0;

  logic        clk;
  logic        n_rst;
  logic        in_decrypt;
  logic [63:0] in_key;
  logic [63:0] in_data;
  logic        in_valid  [NINST];
  logic        out_ready [NINST];
  logic        in_ready  [NINST];
  logic        out_valid [NINST];
  logic        busy      [NINST];
  logic [63:0] out_data  [NINST];

  int n_pass;
  int n_checks;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    des_round_engine #(.UNROLL(1 << g)) u_dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_decrypt (in_decrypt),
      .in_key     (in_key),
      .in_data    (in_data),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_data   (out_data[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 40 edges for out_valid on instance k; returns edges waited and whether in_ready stayed low.
  task automatic wait_out(input int k, output int cyc, output logic rdy_low);
    cyc     = 0;
    rdy_low = 1'b1;
    while (!out_valid[k] && cyc < 40) begin
      if (in_ready[k]) rdy_low = 1'b0;
      step();
      cyc++;
    end
  endtask

  // One full transaction on instance k with out_ready high; starts and ends just after an edge.
  task automatic run_block(input int k, input logic dec, input logic [63:0] key, input logic [63:0] data,
                           input logic [63:0] expd, input int lat, input string tag);
    int   cyc;
    logic rdy_low;
    check({tag, "_rdy_idle"}, 64'(in_ready[k]), 64'd1);
    in_valid[k]  = 1'b1;
    out_ready[k] = 1'b1;
    in_decrypt   = dec;
    in_key       = key;
    in_data      = data;
    step();
    in_valid[k] = 1'b0;
    in_key      = ~key;
    in_data     = ~data;
    in_decrypt  = ~dec;
    wait_out(k, cyc, rdy_low);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_rdy_low"}, 64'({rdy_low, in_ready[k], busy[k]}), 64'b101);
    check({tag, "_data"}, out_data[k], expd);
    step();
    check({tag, "_drain_flags"}, 64'({out_valid[k], in_ready[k], busy[k]}), 64'b010);
    check({tag, "_hold"}, out_data[k], expd);
    out_ready[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc;
    logic rdy_low;
    logic seen;
    n_pass     = 0;
    n_checks   = 0;
    n_rst      = 1'b0;
    in_decrypt = 1'b0;
    in_key     = '0;
    in_data    = '0;
    for (int k = 0; k < NINST; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
    end
    repeat (3) step();
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("rst_flags_u%0d", 1 << k), 64'({in_ready[k], out_valid[k], busy[k]}), 64'b100);
      check($sformatf("rst_data_u%0d", 1 << k), out_data[k], 64'd0);
    end
    n_rst = 1'b1;
    step();

    run_block(0, 1'b0, K1, P1, C1, 16, "t1_enc_u1");
    run_block(0, 1'b1, K1, C1, P1, 16, "t2_dec_u1");
    run_block(2, 1'b0, K3, P3, C3, 4, "t3_enc_u4");
    run_block(1, 1'b0, K3, P3, C3, 8, "t3_enc_u2");
    run_block(3, 1'b0, K3, P3, C3, 2, "t3_enc_u8");
    run_block(4, 1'b0, K3, P3, C3, 1, "t3_enc_u16");
    run_block(4, 1'b1, K3, C3, P3, 1, "t3_dec_u16");
    run_block(4, 1'b0, K1, P1, C1, 1, "t1_enc_u16");

    // Backpressure: consumer stalls while a second block is already offered.
    check("t4_rdy_idle", 64'(in_ready[0]), 64'd1);
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    in_decrypt   = 1'b0;
    in_key       = K1;
    in_data      = P1;
    step();
    in_decrypt = 1'b1;
    in_data    = C1;
    wait_out(0, cyc, rdy_low);
    check("t4_latency", 64'(cyc), 64'd16);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_stall_flags_%0d", i), 64'({out_valid[0], in_ready[0], busy[0]}), 64'b101);
      check($sformatf("t4_stall_data_%0d", i), out_data[0], C1);
      step();
    end
    out_ready[0] = 1'b1;
    step();
    check("t4_drain_flags", 64'({out_valid[0], in_ready[0]}), 64'b01);
    check("t4_drain_hold", out_data[0], C1);
    step();
    check("t4_second_accept", 64'({in_ready[0], busy[0]}), 64'b01);
    in_valid[0] = 1'b0;
    wait_out(0, cyc, rdy_low);
    check("t4_second_latency", 64'(cyc), 64'd16);
    check("t4_second_data", out_data[0], P1);
    step();
    out_ready[0] = 1'b0;

    // Reset in the middle of a transaction discards it.
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    in_decrypt   = 1'b0;
    in_key       = K1;
    in_data      = P1;
    step();
    in_valid[0] = 1'b0;
    repeat (6) step();
    n_rst = 1'b0;
    step();
    check("t5_rst_flags", 64'({in_ready[0], out_valid[0], busy[0]}), 64'b100);
    check("t5_rst_data", out_data[0], 64'd0);
    n_rst = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      step();
      seen |= out_valid[0];
    end
    check("t5_discarded", 64'(seen), 64'd0);
    run_block(0, 1'b1, K1, C1, P1, 16, "t5_dec_u1");

    run_block(0, 1'b0, K6, P1, C1, 16, "t6_parity_u1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
